// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit holding the MIPS HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multE,
  input  logic             divE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               res_neg_q, res_neg_d;
  logic               a_neg_q, a_neg_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;
`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] fast_prod;
`endif

  logic               start, start_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
  logic [WIDTH-1:0]   quo, rem, quo_neg, rem_neg;

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient}.
  always_comb begin
    start     = multE | divE;
    start_div = divE & ~multE;
    abs_a     = srcaE[WIDTH-1] ? -srcaE : srcaE;
    abs_b     = srcbE[WIDTH-1] ? -srcbE : srcbE;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    prod_neg  = -acc_q;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    quo_neg   = -quo;
    rem_neg   = -rem;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    res_neg_d = res_neg_q;
    a_neg_d   = a_neg_q;
    a_d       = a_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
`ifdef MULDIV_FAST_MUL_EN
    b_d       = b_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = srcaE;
          a_neg_d   = srcaE[WIDTH-1];
          res_neg_d = srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
          is_div_d  = start_div;
          cnt_d     = CNTW'(WIDTH - 1);
          dz_d      = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
          b_d       = srcbE;
`endif
          if (start_div) begin
            mag_d     = abs_b;
            acc_d     = {{WIDTH{1'b0}}, abs_a};
            divzero_d = 1'b0;
            dz_d      = (srcbE == '0);
            state_d   = (srcbE == '0) ? FIX : RUN;
          end else begin
            mag_d     = abs_a;
            acc_d     = {{WIDTH{1'b0}}, abs_b};
`ifdef MULDIV_FAST_MUL_EN
            state_d   = FIX;
`else
            state_d   = RUN;
`endif
          end
        end
      end

      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (is_div_q) begin
          // A zero divisor reports all-ones quotient and the raw dividend.
          if (dz_q) begin
            lo_d      = '1;
            hi_d      = a_q;
            divzero_d = 1'b1;
          end else begin
            lo_d = res_neg_q ? quo_neg : quo;
            hi_d = a_neg_q ? rem_neg : rem;
          end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          {hi_d, lo_d} = fast_prod;
`else
          {hi_d, lo_d} = res_neg_q ? prod_neg : acc_q;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      res_neg_q <= 1'b0;
      a_neg_q   <= 1'b0;
      a_q       <= '0;
      mag_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      b_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      res_neg_q <= res_neg_d;
      a_neg_q   <= a_neg_d;
      a_q       <= a_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
`ifdef MULDIV_FAST_MUL_EN
      b_q       <= b_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divzero = divzero_q;

endmodule
